noc_vn_link_arbiter: RTL and testbench
======================================

Name: noc_vn_link_arbiter

Overview:
- Credit-based output scheduler for a network interface injection port.
- Shares one physical NoC link among NUMBEROF_VIRTUAL_NETWORKS injection streams, one per virtual network (VN).
- VN n always travels on virtual channel (VC) n.
- Grants are packet-atomic and rotate round-robin; per-VC credit counters track downstream buffer space.

Parameters:
- FLIT_WIDTH, 64, flit payload width.
- FLIT_TYPE_WIDTH, 2, flit type field width.
- BROADCAST_WIDTH, 1, broadcast flag width.
- VIRTUAL_CHANNEL_ID_WIDTH, 2, VC id width.
- NUMBEROF_VIRTUAL_NETWORKS, 4, number of injection streams; equals NUMBEROF_VIRTUAL_CHANNELS.
- MAX_CREDITS, 8, downstream buffer depth per VC; credit counters reset to this value.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- in_valid, in, NVN, per-VN flit valid.
- in_ready, out, NVN, per-VN flit accepted; combinational.
- in_flit, in, NVN*FLIT_WIDTH, packed flits; VN n occupies bits [n*FLIT_WIDTH +: FLIT_WIDTH].
- in_type, in, NVN*FLIT_TYPE_WIDTH, packed flit types. Encoding: 00 header, 01 body, 10 tail, 11 header_tail.
- in_broadcast, in, NVN*BROADCAST_WIDTH, packed broadcast flags.
- out_valid, out, 1, registered flit valid on the link.
- out_flit, out, FLIT_WIDTH, registered flit.
- out_type, out, FLIT_TYPE_WIDTH, registered type.
- out_broadcast, out, BROADCAST_WIDTH, registered broadcast flag.
- out_vc_id, out, VIRTUAL_CHANNEL_ID_WIDTH, VC of out_flit.
- credit_in, in, NVN, one-cycle pulse per returned downstream slot, per VC.
- credit_count, out, NVN*$clog2(MAX_CREDITS+1), current credits per VC.
- credit_overflow, out, 1, sticky error flag.

Behaviour:
- Reset values (rst_n low at a clk edge):
  - out_valid=0; out_flit, out_type, out_broadcast, out_vc_id = 0.
  - All credit counters = MAX_CREDITS; credit_overflow=0.
  - Lock cleared; RR pointer = 0.
  - in_ready=0 while rst_n is low.
- Reset mid-packet: the lock is dropped and counters restored to MAX_CREDITS with no other effect. Upstream restart is the upstream's responsibility.
- Eligibility: VN n is eligible when in_valid[n]=1 and credit[n]>0. Credit eligibility uses the registered count, so a same-cycle credit_in does not help.
- FSM states:
  - IDLE:
    - Grant the first eligible VN whose in_type is header or header_tail, searching from the RR pointer upward with wrap.
    - A body or tail flit arriving on an unlocked VN is never granted and stalls that VN (protocol error; no recovery).
    - header grant -> LOCKED(n).
    - header_tail grant -> stay IDLE.
  - LOCKED(n):
    - Only VN n is considered. It is granted when eligible, with any type except header or header_tail.
    - tail grant -> IDLE.
    - VN n invalid or out of credit -> hold LOCKED(n); no other VN is granted.
- Grant actions:
  - in_ready[g]=1 for exactly the granted VN in the same cycle; all other bits 0. At most one bit is set per cycle.
  - Next edge: out_* load the flit with out_vc_id=g, and out_valid=1.
  - Cycles with no grant: out_valid=0 at the next edge.
  - Latency is one cycle; throughput is one flit per cycle.
- RR pointer:
  - Updated to g+1 (mod NVN) on any packet-ending grant (tail or header_tail).
  - Unchanged on header or body grants.
- Credits, per VC:
  - Decrement on grant; increment on credit_in.
  - Both in the same cycle: unchanged.
  - Increment when already at MAX_CREDITS: counter holds, and credit_overflow sets and stays set until reset.
  - Decrement at 0 cannot occur, because eligibility requires a credit.
- Output has no backpressure; flow control is purely credit-based.

Test Plan:
- Reset, then header_tail on VN2 only -> in_ready=0100 in cycle 0; cycle 1 out_valid=1, out_vc_id=2, out_flit matches; credit[2] reads 7.
- VN0 sends a 4-flit packet (H,B,B,T) while VN1 holds a header valid throughout -> VN0's four flits go out back-to-back with out_vc_id=0; VN1's header follows in the next cycle.
- All 4 VNs send continuous header_tail flits -> grant order 0,1,2,3,0,... with one flit per cycle; in_ready is one-hot or zero every cycle.
- VN3 sends 9 single-flit packets with no credit_in -> 8 are sent and the 9th stalls with credit[3]=0. Then one credit_in[3] pulse -> the 9th is granted the cycle after the pulse.
- A credit_in[1] pulse and a grant on VN1 in the same cycle, with credit[1]=5 -> credit stays 5. Separately, credit_in[0] with credit[0]=8 -> credit_overflow=1 and stays 1.
- Assert rst_n=0 for one cycle in the middle of a LOCKED(2) packet -> out_valid=0, all credits=8, lock cleared. A new header on VN0 is granted immediately after reset.

Source files
------------

// File: rtl/noc_vn_link_arbiter.sv
// Credit-based, packet-atomic round-robin scheduler that shares one NoC link
// among per-virtual-network injection streams (VN n rides VC n).
module noc_vn_link_arbiter #(
  parameter int FLIT_WIDTH                = 64,
  parameter int FLIT_TYPE_WIDTH           = 2,
  parameter int BROADCAST_WIDTH           = 1,
  parameter int VIRTUAL_CHANNEL_ID_WIDTH  = 2,
  parameter int NUMBEROF_VIRTUAL_NETWORKS = 4,
  parameter int MAX_CREDITS               = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUMBEROF_VIRTUAL_NETWORKS-1:0]  in_valid,
  output logic [NUMBEROF_VIRTUAL_NETWORKS-1:0]  in_ready,
  input  logic [NUMBEROF_VIRTUAL_NETWORKS*FLIT_WIDTH-1:0]      in_flit,
  input  logic [NUMBEROF_VIRTUAL_NETWORKS*FLIT_TYPE_WIDTH-1:0] in_type,
  input  logic [NUMBEROF_VIRTUAL_NETWORKS*BROADCAST_WIDTH-1:0] in_broadcast,
  output logic                                  out_valid,
  output logic [FLIT_WIDTH-1:0]                 out_flit,
  output logic [FLIT_TYPE_WIDTH-1:0]            out_type,
  output logic [BROADCAST_WIDTH-1:0]            out_broadcast,
  output logic [VIRTUAL_CHANNEL_ID_WIDTH-1:0]   out_vc_id,
  input  logic [NUMBEROF_VIRTUAL_NETWORKS-1:0]  credit_in,
  output logic [NUMBEROF_VIRTUAL_NETWORKS*$clog2(MAX_CREDITS+1)-1:0]
                                                credit_count,
  output logic                                  credit_overflow
);

  localparam int NVN = NUMBEROF_VIRTUAL_NETWORKS;
  localparam int FW  = FLIT_WIDTH;
  localparam int TW  = FLIT_TYPE_WIDTH;
  localparam int BW  = BROADCAST_WIDTH;
  localparam int VCW = VIRTUAL_CHANNEL_ID_WIDTH;
  localparam int CW  = $clog2(MAX_CREDITS+1);

  localparam logic [TW-1:0] T_HDR  = TW'(0);
  localparam logic [TW-1:0] T_BODY = TW'(1);
  localparam logic [TW-1:0] T_TAIL = TW'(2);
  localparam logic [TW-1:0] T_HT   = TW'(3);

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_LOCKED = 1'b1;

  localparam logic [CW-1:0] CMAX = CW'(MAX_CREDITS);

  logic           state_q, state_d;
  logic [VCW-1:0] lock_vn_q, lock_vn_d;
  logic [VCW-1:0] rr_q, rr_d;
  logic [CW-1:0]  cred_q [NVN];
  logic [CW-1:0]  cred_d [NVN];
  logic           ovf_q, ovf_d;

  logic           out_valid_q, out_valid_d;
  logic [FW-1:0]  out_flit_q, out_flit_d;
  logic [TW-1:0]  out_type_q, out_type_d;
  logic [BW-1:0]  out_bc_q, out_bc_d;
  logic [VCW-1:0] out_vc_q, out_vc_d;

  logic [NVN-1:0] elig_hdr;
  logic [NVN-1:0] elig_cont;
  logic           gnt;
  logic [VCW-1:0] gnt_vn;
  logic [TW-1:0]  gnt_type;
  logic           is_hdr;
  logic           is_end;
  int             scan;

  // Eligibility is based on registered credits only.
  always_comb begin
    elig_hdr  = '0;
    elig_cont = '0;
    for (int n = 0; n < NVN; n++) begin
      elig_hdr[n] = in_valid[n] && (cred_q[n] != '0) &&
        ((in_type[n*TW +: TW] == T_HDR) ||
         (in_type[n*TW +: TW] == T_HT));
      elig_cont[n] = in_valid[n] && (cred_q[n] != '0) &&
        ((in_type[n*TW +: TW] == T_BODY) ||
         (in_type[n*TW +: TW] == T_TAIL));
    end
  end

  // Locked: only the owner may continue. Idle: rotate from rr_q.
  always_comb begin
    gnt    = 1'b0;
    gnt_vn = '0;
    scan   = 0;
    if (rst_n) begin
      if (state_q == S_LOCKED) begin
        if (elig_cont[lock_vn_q]) begin
          gnt    = 1'b1;
          gnt_vn = lock_vn_q;
        end
      end else begin
        for (int i = 0; i < NVN; i++) begin
          scan = int'(rr_q) + i;
          if (scan >= NVN) scan = scan - NVN;
          if (!gnt && elig_hdr[scan]) begin
            gnt    = 1'b1;
            gnt_vn = VCW'(scan);
          end
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (gnt) in_ready[gnt_vn] = 1'b1;
  end

  assign gnt_type = in_type[int'(gnt_vn)*TW +: TW];
  assign is_hdr   = gnt && (gnt_type == T_HDR);
  assign is_end   = gnt &&
    ((gnt_type == T_TAIL) || (gnt_type == T_HT));

  always_comb begin
    state_d   = state_q;
    lock_vn_d = lock_vn_q;
    rr_d      = rr_q;
    unique case (1'b1)
      is_hdr: begin
        state_d   = S_LOCKED;
        lock_vn_d = gnt_vn;
      end
      is_end: begin
        state_d = S_IDLE;
        rr_d    = (int'(gnt_vn) == NVN-1) ?
                  '0 : gnt_vn + VCW'(1);
      end
      default: ;
    endcase
  end

  // A return and a grant in the same cycle cancel out.
  always_comb begin
    ovf_d = ovf_q;
    for (int n = 0; n < NVN; n++) begin
      cred_d[n] = cred_q[n];
      if (credit_in[n] &&
          !(gnt && (int'(gnt_vn) == n))) begin
        if (cred_q[n] == CMAX) ovf_d = 1'b1;
        else cred_d[n] = cred_q[n] + CW'(1);
      end else if (!credit_in[n] && gnt &&
                   (int'(gnt_vn) == n)) begin
        cred_d[n] = cred_q[n] - CW'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = gnt;
    out_flit_d  = out_flit_q;
    out_type_d  = out_type_q;
    out_bc_d    = out_bc_q;
    out_vc_d    = out_vc_q;
    if (gnt) begin
      out_flit_d = in_flit[int'(gnt_vn)*FW +: FW];
      out_type_d = gnt_type;
      out_bc_d   = in_broadcast[int'(gnt_vn)*BW +: BW];
      out_vc_d   = gnt_vn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lock_vn_q   <= '0;
      rr_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_type_q  <= '0;
      out_bc_q    <= '0;
      out_vc_q    <= '0;
      for (int n = 0; n < NVN; n++) cred_q[n] <= CMAX;
    end else begin
      state_q     <= state_d;
      lock_vn_q   <= lock_vn_d;
      rr_q        <= rr_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_type_q  <= out_type_d;
      out_bc_q    <= out_bc_d;
      out_vc_q    <= out_vc_d;
      for (int n = 0; n < NVN; n++) cred_q[n] <= cred_d[n];
    end
  end

  for (genvar n = 0; n < NVN; n++) begin : g_cc
    assign credit_count[n*CW +: CW] = cred_q[n];
  end

  assign out_valid       = out_valid_q;
  assign out_flit        = out_flit_q;
  assign out_type        = out_type_q;
  assign out_broadcast   = out_bc_q;
  assign out_vc_id       = out_vc_q;
  assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_noc_vn_link_arbiter.sv
// Randomized bench for noc_vn_link_arbiter with a reference model
// of the grant, credit and output rules.
module tb_noc_vn_link_arbiter;
  localparam int N    = 4;
  localparam int FW   = 64;
  localparam int TW   = 2;
  localparam int CW   = 4;
  localparam int MAXC = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      in_valid = '0;
  logic [N-1:0]      in_ready;
  logic [N*FW-1:0]   in_flit = '0;
  logic [N*TW-1:0]   in_type = '0;
  logic [N-1:0]      in_broadcast = '0;
  logic              out_valid;
  logic [FW-1:0]     out_flit;
  logic [TW-1:0]     out_type;
  logic [0:0]        out_broadcast;
  logic [1:0]        out_vc_id;
  logic [N-1:0]      credit_in = '0;
  logic [N*CW-1:0]   credit_count;
  logic              credit_overflow;

  noc_vn_link_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_flit(in_flit), .in_type(in_type),
    .in_broadcast(in_broadcast),
    .out_valid(out_valid), .out_flit(out_flit),
    .out_type(out_type), .out_broadcast(out_broadcast),
    .out_vc_id(out_vc_id), .credit_in(credit_in),
    .credit_count(credit_count),
    .credit_overflow(credit_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference state: owner<0 means no packet in flight.
  int         m_owner = -1;
  int         m_rr = 0;
  int         m_cred [N];
  bit         m_ovf = 0;
  bit         e_valid = 0;
  bit         e_rst = 1;
  int         e_vc = 0;
  logic [FW-1:0] e_flit = '0;
  logic [1:0] e_type = '0;
  logic       e_bc = 1'b0;
  int         last_g = -1;
  logic [N-1:0] last_rdy;
  int         pos [N];
  int         len [N];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] typ(input int n);
    return in_type[n*TW +: TW];
  endfunction

  function automatic int predict();
    int g;
    g = -1;
    if (!rst_n) return -1;
    if (m_owner >= 0) begin
      if (in_valid[m_owner] && m_cred[m_owner] > 0 &&
          (typ(m_owner) == 2'd1 || typ(m_owner) == 2'd2))
        g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int n;
        n = (m_rr + k) % N;
        if (g < 0 && in_valid[n] && m_cred[n] > 0 &&
            (typ(n) == 2'd0 || typ(n) == 2'd3))
          g = n;
      end
    end
    return g;
  endfunction

  task automatic model_update(input int g);
    if (!rst_n) begin
      m_owner = -1; m_rr = 0; m_ovf = 0;
      for (int n = 0; n < N; n++) m_cred[n] = MAXC;
      e_valid = 0; e_rst = 1;
      return;
    end
    for (int n = 0; n < N; n++) begin
      if (credit_in[n] && g != n) begin
        if (m_cred[n] == MAXC) m_ovf = 1;
        else m_cred[n]++;
      end else if (!credit_in[n] && g == n) begin
        m_cred[n]--;
      end
    end
    if (g >= 0) begin
      e_valid = 1; e_rst = 0; e_vc = g;
      e_flit = in_flit[g*FW +: FW];
      e_type = typ(g);
      e_bc = in_broadcast[g];
      if (e_type == 2'd0) m_owner = g;
      else if (e_type == 2'd2 || e_type == 2'd3) begin
        m_owner = -1;
        m_rr = (g + 1) % N;
      end
    end else begin
      e_valid = 0;
    end
  endtask

  // Call just after inputs are driven at the falling edge.
  task automatic tick();
    int g;
    logic [N-1:0] er;
    #1;
    g = predict();
    er = (g < 0) ? '0 : N'(1 << g);
    last_rdy = in_ready;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    model_update(g);
    last_g = g;
    #1;
    chk("out_valid", out_valid, e_valid);
    if (e_valid || e_rst) begin
      chk("out_vc", out_vc_id, e_rst ? 0 : e_vc);
      chk("out_flit", out_flit, e_rst ? '0 : e_flit);
      chk("out_type", out_type, e_rst ? '0 : e_type);
      chk("out_bc", out_broadcast, e_rst ? '0 : e_bc);
    end
    for (int n = 0; n < N; n++)
      chk($sformatf("credit%0d", n),
          credit_count[n*CW +: CW], m_cred[n]);
    chk("overflow", credit_overflow, m_ovf);
  endtask

  task automatic rand_flits();
    for (int n = 0; n < N; n++)
      in_flit[n*FW +: FW] = {$urandom, $urandom};
  endtask

  task automatic set_in(input logic [N-1:0] v,
                        input logic [N*TW-1:0] t);
    @(negedge clk);
    in_valid = v;
    in_type = t;
    rand_flits();
    in_broadcast = N'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = '0;
    credit_in = '0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] src_type(input int n);
    if (len[n] == 1) return 2'd3;
    if (pos[n] == 0) return 2'd0;
    if (pos[n] == len[n] - 1) return 2'd2;
    return 2'd1;
  endfunction

  initial begin
    for (int n = 0; n < N; n++) begin
      m_cred[n] = MAXC;
      pos[n] = 0;
      len[n] = $urandom_range(1, 4);
    end
    // Reset state
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    tick_again: begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single header_tail on VN2
    in_valid = 4'b0100;
    in_type = 8'b0011_0000;
    rand_flits();
    tick();
    chk("t1_rdy", last_rdy, 4'b0100);
    chk("t1_vc", out_vc_id, 2);
    chk("t1_cred2", credit_count[2*CW +: CW], 7);
    set_in('0, '0);
    tick();

    // VN3 runs out of credit, then one return unblocks it
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(4'b1000, 8'b1100_0000);
      tick();
    end
    set_in(4'b1000, 8'b1100_0000);
    tick();
    chk("t3_stall_rdy", last_rdy, 4'b0000);
    chk("t3_cred0", credit_count[3*CW +: CW], 0);
    set_in(4'b1000, 8'b1100_0000);
    credit_in = 4'b1000;
    tick();
    chk("t3_pulse_rdy", last_rdy, 4'b0000);
    set_in(4'b1000, 8'b1100_0000);
    credit_in = '0;
    tick();
    chk("t3_resume_rdy", last_rdy, 4'b1000);
    set_in('0, '0);
    tick();

    // Random traffic with legal packets and occasional reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      for (int n = 0; n < N; n++) begin
        in_valid[n] = ($urandom_range(0, 3) != 0);
        in_type[n*TW +: TW] = src_type(n);
        in_broadcast[n] = 1'($urandom);
        credit_in[n] = (m_cred[n] < MAXC) &&
                       ($urandom_range(0, 2) == 0);
      end
      rand_flits();
      tick();
      if (!rst_n) begin
        for (int n = 0; n < N; n++) pos[n] = 0;
      end else if (last_g >= 0) begin
        pos[last_g]++;
        if (pos[last_g] == len[last_g]) begin
          pos[last_g] = 0;
          len[last_g] = $urandom_range(1, 4);
        end
      end
    end

    // Credit return at full count is sticky overflow
    do_reset();
    in_valid = '0;
    credit_in = 4'b0001;
    tick();
    chk("ovf_set", credit_overflow, 1'b1);
    @(negedge clk);
    credit_in = '0;
    tick();
    @(negedge clk);
    tick();
    chk("ovf_sticky", credit_overflow, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
